// File: rtl/cw_pkg.sv
// Shared types for the constant-weight position decoder: FSM states, width defaults
// and the registered step returned by the external best-d stage.
package cw_pkg;

  localparam int N_W_DEF = 17;
  localparam int T_W_DEF = 4;
  localparam int D_W     = 16;
  localparam int U_W     = 4;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    WAIT_D,
    READ_FLAG,
    READ_IDX,
    EMIT,
    FILL,
    DONE
  } cw_state_t;

  // Power-of-two step d and its log2 u, captured when leaving WAIT_D
  typedef struct packed {
    logic [D_W-1:0] d;
    logic [U_W-1:0] u;
  } step_t;

endpackage

// File: rtl/cw_bit_shifter.sv
// Collects len bits MSB-first into value; load clears and arms, shift takes one bit.
// Single-cycle update; shift requests beyond len bits are ignored.
module cw_bit_shifter
  import cw_pkg::*;
#(
  parameter int W = N_W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic [U_W-1:0] len,
  input  logic           shift,
  input  logic           bit_in,
  output logic [W-1:0]   value,
  output logic [W-1:0]   shifted,
  output logic           last
);
  logic [U_W-1:0] cnt;

  // shifted is the value the next accepted bit produces, so the owner can use it on the same edge
  assign shifted = {value[W-2:0], bit_in};
  assign last    = (cnt == U_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
      cnt   <= '0;
    end else if (load) begin
      value <= '0;
      cnt   <= len;
    end else if (shift && cnt != '0) begin
      value <= shifted;
      cnt   <= cnt - U_W'(1);
    end
  end

endmodule

// File: rtl/cw_pos_decoder.sv
// Constant-weight code decoder: consumes a serial flag/index stream and emits one-positions.
// D_LAT wait per step for the external best-d stage; stalls on bit_valid low or pos_ready low.
module cw_pos_decoder
  import cw_pkg::*;
#(
  parameter int D_LAT = 3,
  parameter int N_W   = N_W_DEF,
  parameter int T_W   = T_W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N_W-1:0] n_init,
  input  logic [T_W-1:0] t_init,
  output logic           busy,
  output logic           done,
  output logic           err,
  input  logic           bit_in,
  input  logic           bit_valid,
  output logic           bit_ready,
  output logic [N_W-1:0] n_out,
  output logic [T_W-1:0] t_out,
  input  logic [15:0]    d_in,
  input  logic [3:0]     u_in,
  output logic [N_W-1:0] pos_out,
  output logic           pos_valid,
  input  logic           pos_ready
);
  localparam logic [N_W-1:0] N_ONE     = N_W'(1);
  localparam logic [T_W-1:0] T_ONE     = T_W'(1);
  localparam logic [15:0]    WAIT_INIT = 16'(D_LAT);

  cw_state_t      state;
  step_t          step_q;
  logic [N_W-1:0] n;
  logic [N_W-1:0] acc;
  logic [T_W-1:0] t;
  logic [15:0]    wcnt;
  logic [N_W-1:0] idx;
  logic [N_W-1:0] idx_shift;
  logic [N_W-1:0] d_ext;
  logic [N_W-1:0] t_ext;
  logic           bit_xfer;
  logic           sh_load;
  logic           sh_shift;
  logic           sh_last;
  logic [U_W-1:0] sh_len;

  assign n_out    = n;
  assign t_out    = t;
  assign d_ext    = N_W'(step_q.d);
  assign t_ext    = N_W'(t);
  assign bit_xfer = bit_valid && bit_ready;

  // A zero flag bit arms the index collector; start clears any stale index
  assign sh_load  = (state == IDLE && start) || (state == READ_FLAG && bit_xfer && !bit_in);
  assign sh_len   = (state == READ_FLAG) ? step_q.u : '0;
  assign sh_shift = (state == READ_IDX) && bit_xfer;

  cw_bit_shifter #(.W(N_W)) u_shifter (
    .clk     (clk),
    .rst     (rst),
    .load    (sh_load),
    .len     (sh_len),
    .shift   (sh_shift),
    .bit_in  (bit_in),
    .value   (idx),
    .shifted (idx_shift),
    .last    (sh_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      n         <= '0;
      t         <= '0;
      acc       <= '0;
      wcnt      <= '0;
      step_q    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      bit_ready <= 1'b0;
      pos_out   <= '0;
      pos_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            n     <= n_init;
            t     <= t_init;
            acc   <= '0;
            err   <= 1'b0;
            busy  <= 1'b1;
            state <= CHECK;
          end
        end
        CHECK: begin
          if (t == '0) begin
            done  <= 1'b1;
            state <= DONE;
          end else if (n == t_ext) begin
            pos_out   <= acc;
            pos_valid <= 1'b1;
            state     <= FILL;
          end else if (n < t_ext) begin
            err   <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            wcnt  <= WAIT_INIT;
            state <= WAIT_D;
          end
        end
        WAIT_D: begin
          // A zero latency still spends one cycle here so d_in/u_in follow n_out/t_out
          if (wcnt <= 16'd1) begin
            wcnt      <= '0;
            step_q.d  <= d_in;
            step_q.u  <= u_in;
            bit_ready <= 1'b1;
            state     <= READ_FLAG;
          end else begin
            wcnt <= wcnt - 16'd1;
          end
        end
        READ_FLAG: begin
          if (bit_xfer) begin
            if (bit_in) begin
              bit_ready <= 1'b0;
              if (d_ext < n) begin
                acc   <= acc + d_ext;
                n     <= n - d_ext;
                state <= CHECK;
              end else begin
                err   <= 1'b1;
                done  <= 1'b1;
                state <= DONE;
              end
            end else if (step_q.u == '0) begin
              bit_ready <= 1'b0;
              pos_out   <= acc;
              pos_valid <= (n != '0);
              state     <= EMIT;
            end else begin
              state <= READ_IDX;
            end
          end
        end
        READ_IDX: begin
          if (bit_xfer && sh_last) begin
            bit_ready <= 1'b0;
            pos_out   <= acc + idx_shift;
            pos_valid <= (idx_shift < n);
            state     <= EMIT;
          end
        end
        EMIT: begin
          // An index at or beyond the remaining length is a corrupt stream: no handshake
          if (idx >= n) begin
            pos_valid <= 1'b0;
            err       <= 1'b1;
            done      <= 1'b1;
            state     <= DONE;
          end else if (pos_ready) begin
            acc       <= acc + idx + N_ONE;
            n         <= n - idx - N_ONE;
            t         <= t - T_ONE;
            pos_valid <= 1'b0;
            state     <= CHECK;
          end
        end
        FILL: begin
          if (pos_ready) begin
            acc <= acc + N_ONE;
            n   <= n - N_ONE;
            t   <= t - T_ONE;
            if (t == T_ONE) begin
              pos_valid <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              pos_out <= pos_out + N_ONE;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cw_pos_decoder.sv
// Directed scenarios plus randomized jobs checked against a loop-level decoding model.
module tb_cw_pos_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [16:0] n_init;
  logic [3:0]  t_init;
  logic        busy, done, err;
  logic        bit_in, bit_valid, bit_ready;
  logic [16:0] n_out;
  logic [3:0]  t_out;
  logic [15:0] d_in;
  logic [3:0]  u_in;
  logic [16:0] pos_out;
  logic        pos_valid, pos_ready;

  int total = 0;
  int bad   = 0;

  logic        fixed_mode;
  logic [15:0] fix_d;
  logic [3:0]  fix_u;
  int          u_calc;

  bit bits_arr [256];
  int exp_q[$];
  int got_q[$];
  int exp_err, exp_used, got_used, got_done;

  cw_pos_decoder dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .n_init    (n_init),
    .t_init    (t_init),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .bit_ready (bit_ready),
    .n_out     (n_out),
    .t_out     (t_out),
    .d_in      (d_in),
    .u_in      (u_in),
    .pos_out   (pos_out),
    .pos_valid (pos_valid),
    .pos_ready (pos_ready)
  );

  always #5 clk = ~clk;

  // Best-d stage: largest power of two d with t*d <= n
  function automatic int calc_u(input int n, input int t);
    int u;
    u = 0;
    if (t > 0 && n > t)
      while (u < 15 && (t << (u + 1)) <= n) u++;
    return u;
  endfunction

  assign u_calc = calc_u(int'(n_out), int'(t_out));
  assign d_in   = fixed_mode ? fix_d : 16'(1 << u_calc);
  assign u_in   = fixed_mode ? fix_u : 4'(u_calc);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_bit_ready"}, bit_ready, 0);
    chk({tag, "_pos_valid"}, pos_valid, 0);
    chk({tag, "_n_out"}, n_out, 0);
    chk({tag, "_t_out"}, t_out, 0);
    chk({tag, "_pos_out"}, pos_out, 0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_zero_outputs(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_start(input int n0, input int t0);
    @(negedge clk);
    n_init = 17'(n0);
    t_init = 4'(t0);
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    int c;
    c = 0;
    while (!bit_ready && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk("bit_ready_wait", bit_ready, 1);
    bit_valid = 1'b1;
    bit_in    = b;
    @(negedge clk);
    bit_valid = 1'b0;
  endtask

  task automatic wait_pos(input string tag);
    int c;
    c = 0;
    while (!pos_valid && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk({tag, "_pos_valid"}, pos_valid, 1);
  endtask

  // Reference decoder over the bit array, following the walk-down rules directly
  task automatic model_job(input int n0, input int t0);
    int n, t, acc, u, d, p, idx;
    exp_q.delete();
    exp_err = 0;
    p = 0; n = n0; t = t0; acc = 0;
    while (t > 0) begin
      if (n == t) begin
        for (int k = 0; k < t; k++) exp_q.push_back(acc + k);
        break;
      end
      if (n < t) begin
        exp_err = 1;
        break;
      end
      u = calc_u(n, t);
      d = 1 << u;
      if (bits_arr[p % 256]) begin
        p++;
        if (d < n) begin
          acc += d;
          n -= d;
        end else begin
          exp_err = 1;
          break;
        end
      end else begin
        p++;
        idx = 0;
        for (int k = 0; k < u; k++) begin
          idx = idx * 2 + int'(bits_arr[p % 256]);
          p++;
        end
        if (idx >= n) begin
          exp_err = 1;
          break;
        end
        exp_q.push_back(acc + idx);
        acc += idx + 1;
        n -= idx + 1;
        t--;
      end
    end
    exp_used = p;
  endtask

  task automatic run_job(input int n0, input int t0, input int stall);
    int cyc;
    got_q.delete();
    got_used = 0;
    got_done = 0;
    do_start(n0, t0);
    cyc = 0;
    while (got_done == 0 && cyc < 4000) begin
      if (done) begin
        got_done = 1;
      end else begin
        bit_valid = ($urandom_range(0, 99) >= stall);
        bit_in    = bits_arr[got_used % 256];
        pos_ready = ($urandom_range(0, 99) >= stall);
        if (bit_valid && bit_ready) got_used++;
        if (pos_valid && pos_ready) got_q.push_back(int'(pos_out));
        @(negedge clk);
        cyc++;
      end
    end
    bit_valid = 1'b0;
    pos_ready = 1'b0;
    chk("job_done_seen", got_done, 1);
  endtask

  task automatic compare_job(input string tag);
    chk({tag, "_err"}, err, exp_err);
    chk({tag, "_bits_used"}, got_used, exp_used);
    chk({tag, "_pos_count"}, got_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size(); k++)
      chk({tag, "_pos"}, (k < got_q.size()) ? got_q[k] : -1, exp_q[k]);
  endtask

  initial begin
    int cnt, saw_pv;
    rst = 1'b1; start = 1'b0; n_init = '0; t_init = '0;
    bit_in = 1'b0; bit_valid = 1'b0; pos_ready = 1'b0;
    fixed_mode = 1'b1; fix_d = 16'd4; fix_u = 4'd2;

    #2;
    check_zero_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // n=16 t=9, d=4: flag 0 then index 10b -> position 2
    do_start(16, 9);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    wait_pos("s1");
    chk("s1_pos_out", pos_out, 2);
    pos_ready = 1'b1;
    @(negedge clk);
    pos_ready = 1'b0;
    chk("s1_n_out", n_out, 13);
    chk("s1_t_out", t_out, 8);
    chk("s1_pos_valid_after", pos_valid, 0);
    do_reset("s1_rst");

    // Flag 1 skips d=4 positions; a start while busy is ignored
    do_start(16, 9);
    send_bit(1'b1);
    chk("s2_n_out", n_out, 12);
    chk("s2_no_pos", pos_valid, 0);
    do_start(7, 2);
    chk("s2_ignored_n", n_out, 12);
    chk("s2_ignored_t", t_out, 9);
    chk("s2_busy", busy, 1);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
    wait_pos("s2");
    chk("s2_pos_acc", pos_out, 4);

    // Hold pos_ready low with bit_valid toggling
    for (int k = 0; k < 5; k++) begin
      bit_valid = k[0];
      bit_in    = 1'b1;
      @(negedge clk);
      chk("s3_pos_hold", pos_out, 4);
      chk("s3_valid_hold", pos_valid, 1);
      chk("s3_no_bit_ready", bit_ready, 0);
    end
    bit_valid = 1'b0;
    pos_ready = 1'b1;
    @(negedge clk);
    pos_ready = 1'b0;
    chk("s3_n_out", n_out, 11);
    chk("s3_t_out", t_out, 8);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    wait_pos("s3_next");
    chk("s3_next_pos", pos_out, 6);
    do_reset("s3_rst");

    // Reset in the middle of the index field
    do_start(16, 9);
    send_bit(1'b0); send_bit(1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_zero_outputs("s4_rst");
    @(negedge clk);
    rst = 1'b0;
    bit_valid = 1'b1; bit_in = 1'b0; pos_ready = 1'b1;
    saw_pv = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (pos_valid || busy || bit_ready) saw_pv = 1;
    end
    chk("s4_quiet_after_rst", saw_pv, 0);
    bit_valid = 1'b0; pos_ready = 1'b0;
    do_start(16, 9);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    wait_pos("s4_restart");
    chk("s4_restart_pos", pos_out, 2);
    do_reset("s4_rst2");

    // Index beyond remaining length: n=5 t=2, d=8, index 111b
    fix_d = 16'd8; fix_u = 4'd3;
    do_start(5, 2);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    cnt = 0; saw_pv = 0;
    while (!done && cnt < 20) begin
      if (pos_valid) saw_pv = 1;
      @(negedge clk);
      cnt++;
    end
    chk("s5_done", done, 1);
    chk("s5_no_pos", saw_pv, 0);
    chk("s5_err", err, 1);
    @(negedge clk);
    chk("s5_err_sticky", err, 1);
    chk("s5_idle_busy", busy, 0);

    // t=0: immediate done, new start clears err
    do_start(9, 0);
    chk("s6_err_cleared", err, 0);
    cnt = 1; saw_pv = 0;
    while (!done && cnt < 10) begin
      if (pos_valid) saw_pv = 1;
      @(negedge clk);
      cnt++;
    end
    chk("s6_done_latency_ok", (cnt <= 3) ? 1 : 0, 1);
    chk("s6_no_pos", saw_pv, 0);
    do_reset("s6_rst");

    // n=t=3 fills positions 0,1,2
    fixed_mode = 1'b0;
    for (int k = 0; k < 256; k++) bits_arr[k] = 1'($urandom_range(0, 1));
    model_job(3, 3);
    run_job(3, 3, 0);
    chk("s7_count", got_q.size(), 3);
    for (int k = 0; k < 3; k++)
      chk("s7_pos", (k < got_q.size()) ? got_q[k] : -1, k);
    chk("s7_err", err, 0);
    compare_job("s7");

    // Randomized jobs against the model
    for (int j = 0; j < 30; j++) begin
      int n0, t0;
      for (int k = 0; k < 256; k++) bits_arr[k] = 1'($urandom_range(0, 1));
      n0 = $urandom_range(0, 40);
      t0 = $urandom_range(0, 8);
      model_job(n0, t0);
      run_job(n0, t0, 30);
      compare_job("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
